credit_write_arbiter: RTL and testbench

Shares the write port of the credit-based async FIFO between `NUM_REQ` write-clock-domain requesters. Keeps a local credit count that mirrors free FIFO slots and arbitrates round-robin with a bounded burst per grant. Drives `wvalid`/`wdata` into the FIFO and consumes the FIFO's `wcredit` return pulses, so the FIFO write port is never overrun.

---
 rtl/credit_arb_pkg.sv | 15 +
 rtl/credit_write_arbiter_rr_picker.sv | 35 +++
 rtl/credit_write_arbiter.sv | 130 +++++++++++++
 tb/tb_credit_write_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_arb_pkg.sv
// Shared types and helpers for the credit-based write arbiter.
// Holds the arbiter state encoding and the credit counter width rule.
package credit_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_HOLD
   } arb_state_t;

   // Counter must represent every value from 0 up to and including depth.
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/credit_write_arbiter_rr_picker.sv
// Cyclic priority encoder: first set request at or after start, wrapping; purely combinational.
// Zero latency, no backpressure (found low when no request is set).
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   int            j;
   logic [IW-1:0] cand;

   // Walk from the farthest offset down so the closest hit is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = 0;
      cand  = '0;
      for (int off = N - 1; off >= 0; off--) begin
         j = int'(start) + off;
         if (j >= N) begin
            j = j - N;
         end
         cand = IW'(j);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/credit_write_arbiter.sv
// Round-robin, burst-bounded sharing of one credit-gated FIFO write port; 1-cycle issue to wvalid.
// Backpressure: req_ready drops when credits hit zero, freezing the current owner and burst.
module credit_write_arbiter
   import credit_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_BURST  = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic                              wvalid,
   output logic [DATA_WIDTH-1:0]             wdata,
   input  logic                              wcredit,
   output logic [credit_w(FIFO_DEPTH)-1:0]   credit_count,
   output logic [$clog2(NUM_REQ)-1:0]        grant_id,
   output logic                              err_overflow
);

   localparam int CW = credit_w(FIFO_DEPTH);
   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CREDIT_FULL = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
   localparam logic [IW-1:0] LAST_REQ    = IW'(NUM_REQ - 1);

   arb_state_t          state, state_n;
   logic [IW-1:0]       owner, owner_n, owner_inc;
   logic [IW-1:0]       rr_ptr, rr_ptr_n;
   logic [IW-1:0]       pick_start, pick_idx, sel_idx;
   logic [BW-1:0]       burst_cnt, burst_n;
   logic                pick_found, have_credit, owner_cont, issue;
   logic [DATA_WIDTH-1:0] issue_dat;

   assign have_credit = (credit_count != '0);
   assign owner_inc   = (owner == LAST_REQ) ? '0 : owner + 1'b1;
   assign owner_cont  = (state == ARB_HOLD) && req_valid[owner] && (burst_cnt < BURST_LIMIT);
   // Searching from owner+1 makes the outgoing owner the last candidate on rotation.
   assign pick_start  = (state == ARB_HOLD) ? owner_inc : rr_ptr;
   assign grant_id    = owner;

   rr_picker #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_picker (
      .req   (req_valid),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_n  = state;
      owner_n  = owner;
      burst_n  = burst_cnt;
      rr_ptr_n = rr_ptr;
      issue    = 1'b0;
      sel_idx  = owner;
      // Zero credits is a stall: every arbitration register holds its value.
      if (reset_n && have_credit) begin
         if (owner_cont) begin
            issue   = 1'b1;
            burst_n = burst_cnt + 1'b1;
         end else begin
            if (state == ARB_HOLD) begin
               rr_ptr_n = owner_inc;
            end
            if (pick_found) begin
               issue   = 1'b1;
               sel_idx = pick_idx;
               state_n = ARB_HOLD;
               owner_n = pick_idx;
               burst_n = BW'(1);
            end else begin
               state_n = ARB_IDLE;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      issue_dat = '0;
      if (issue) begin
         req_ready[sel_idx] = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_idx == IW'(i)) begin
            issue_dat = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ARB_IDLE;
         owner        <= '0;
         burst_cnt    <= '0;
         rr_ptr       <= '0;
         wvalid       <= 1'b0;
         wdata        <= '0;
         credit_count <= CREDIT_FULL;
         err_overflow <= 1'b0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         burst_cnt <= burst_n;
         rr_ptr    <= rr_ptr_n;
         wvalid    <= issue;
         if (issue) begin
            wdata <= issue_dat;
         end
         // A simultaneous issue and return cancel out; a return into a full counter is an error.
         if (issue && !wcredit) begin
            credit_count <= credit_count - 1'b1;
         end else if (!issue && wcredit) begin
            if (credit_count == CREDIT_FULL) begin
               err_overflow <= 1'b1;
            end else begin
               credit_count <= credit_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_credit_write_arbiter.sv
// Randomised and directed bench for credit_write_arbiter against a rule-level reference model.
module tb_credit_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int D  = 16;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            wvalid;
   logic [DW-1:0]   wdata;
   logic            wcredit;
   logic [4:0]      credit_count;
   logic [1:0]      grant_id;
   logic            err_overflow;

   always #5 clk = ~clk;

   credit_write_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (D),
      .MAX_BURST  (MB)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .wvalid       (wvalid),
      .wdata        (wdata),
      .wcredit      (wcredit),
      .credit_count (credit_count),
      .grant_id     (grant_id),
      .err_overflow (err_overflow)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: free slots, sticky error, current owner and its run length.
   int            m_cnt   = D;
   bit            m_err   = 1'b0;
   bit            m_hold  = 1'b0;
   int            m_owner = 0;
   int            m_run   = 0;
   int            m_ptr   = 0;
   bit            m_wvalid = 1'b0;
   logic [DW-1:0] m_wdata = '0;
   logic [N-1:0]  rdy_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit owner_keeps();
      return m_hold && req_valid[m_owner] && (m_run < MB);
   endfunction

   function automatic int model_pick();
      int start;
      if (!reset_n || m_cnt == 0) return -1;
      if (owner_keeps()) return m_owner;
      start = m_hold ? (m_owner + 1) % N : m_ptr;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic cycle();
      int p;
      bit keep;
      req_data = $urandom();
      #1;
      p    = model_pick();
      keep = owner_keeps();
      rdy_seen = req_ready;
      chk("req_ready", req_ready, (p >= 0) ? (32'd1 << p) : 32'd0);
      @(posedge clk);
      if (!reset_n) begin
         m_cnt = D; m_err = 0; m_hold = 0; m_owner = 0; m_run = 0; m_ptr = 0;
         m_wvalid = 0; m_wdata = '0;
      end else begin
         m_wvalid = (p >= 0);
         if (p >= 0) m_wdata = req_data[p*DW +: DW];
         if (m_cnt > 0) begin
            if (keep) begin
               m_run++;
            end else begin
               if (m_hold) m_ptr = (m_owner + 1) % N;
               if (p >= 0) begin
                  m_hold = 1; m_owner = p; m_run = 1;
               end else begin
                  m_hold = 0;
               end
            end
         end
         if (p >= 0 && !wcredit) m_cnt--;
         else if (p < 0 && wcredit) begin
            if (m_cnt == D) m_err = 1;
            else m_cnt++;
         end
      end
      #1;
      chk("wvalid", wvalid, m_wvalid);
      chk("wdata", wdata, m_wdata);
      chk("credit_count", credit_count, m_cnt);
      chk("err_overflow", err_overflow, m_err);
      chk("grant_id", grant_id, m_owner);
   endtask

   task automatic do_reset();
      reset_n = 1'b0; req_valid = '0; wcredit = 1'b0;
      cycle();
      cycle();
      reset_n = 1'b1;
   endtask

   initial begin
      int issues;
      int prob;
      reset_n = 1'b0; req_valid = '0; wcredit = 1'b0; req_data = '0;

      // Reset state.
      do_reset();
      chk("rst_ready", req_ready, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_credit", credit_count, D);
      chk("rst_gid", grant_id, 0);
      chk("rst_err", err_overflow, 0);

      // Single requester drains all credits.
      req_valid = 4'b0001;
      issues = 0;
      repeat (20) begin
         cycle();
         if (wvalid) issues++;
      end
      chk("drain_issues", issues, D);
      chk("drain_credit", credit_count, 0);
      chk("drain_ready", req_ready, 0);

      // Return all credits with no requests.
      req_valid = '0;
      repeat (D) begin wcredit = 1'b1; cycle(); end
      wcredit = 1'b0;
      cycle();
      chk("refill_credit", credit_count, D);

      // All four requesters: bursts of four rotate 0,1,2,3.
      do_reset();
      req_valid = 4'hF;
      for (int k = 0; k < 24; k++) begin
         wcredit = (m_cnt < D);
         cycle();
         chk("rr_seq_ready", rdy_seen, 32'd1 << ((k / MB) % N));
         chk("rr_seq_gid", grant_id, (k / MB) % N);
      end
      wcredit = 1'b0;

      // Owner 2 drops after two issues; 3 takes over with a fresh burst.
      do_reset();
      req_valid = 4'b1100;
      cycle();
      cycle();
      req_valid = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("drop_handover", rdy_seen, (k < MB) ? 32'd8 : 32'd1);
      end

      // Issue and return together at one credit.
      do_reset();
      req_valid = 4'b0001;
      repeat (D - 1) cycle();
      chk("one_credit", credit_count, 1);
      wcredit = 1'b1;
      cycle();
      chk("one_credit_issue", rdy_seen, 1);
      chk("one_credit_hold", credit_count, 1);
      wcredit = 1'b0;
      cycle();
      chk("one_credit_regrant", rdy_seen, 1);
      chk("one_credit_zero", credit_count, 0);

      // Credits run out mid-burst; the burst resumes where it stopped.
      do_reset();
      req_valid = 4'b0010;
      cycle();
      req_valid = 4'b0001;
      repeat (14) cycle();
      chk("mid_credit", credit_count, 1);
      req_valid = 4'b0011;
      cycle();
      chk("mid_last_issue", rdy_seen, 1);
      repeat (3) begin
         cycle();
         chk("mid_stall", rdy_seen, 0);
      end
      wcredit = 1'b1;
      cycle();
      wcredit = 1'b0;
      cycle();
      chk("mid_resume", rdy_seen, 1);
      chk("mid_resume_gid", grant_id, 0);
      repeat (2) cycle();
      wcredit = 1'b1;
      cycle();
      wcredit = 1'b0;
      cycle();
      chk("mid_rotate_after_max", rdy_seen, 2);

      // Overflow is sticky; reset mid-burst clears everything.
      do_reset();
      wcredit = 1'b1;
      cycle();
      wcredit = 1'b0;
      chk("ovf_err", err_overflow, 1);
      chk("ovf_credit", credit_count, D);
      req_valid = 4'hF;
      repeat (3) cycle();
      chk("ovf_sticky", err_overflow, 1);
      reset_n = 1'b0;
      cycle();
      chk("rst_mid_ready", rdy_seen, 0);
      chk("rst_mid_wvalid", wvalid, 0);
      chk("rst_mid_wdata", wdata, 0);
      chk("rst_mid_credit", credit_count, D);
      chk("rst_mid_gid", grant_id, 0);
      chk("rst_mid_err", err_overflow, 0);
      reset_n = 1'b1;

      // Random traffic with varying credit return rate.
      prob = 2;
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) prob = $urandom_range(0, 4);
         req_valid = N'($urandom());
         wcredit   = (m_cnt < D) && ($urandom_range(0, 3) < prob);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
